// File: rtl/ka_overlap_accumulator_if.sv
// Term/product stream bundle for ka_overlap_accumulator.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface ka_overlap_accumulator_if #(
    parameter int N = 30
);
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_tag;
    logic [N-2:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-2:0] out_data;
    logic           seq_err;

    modport master (
        output in_valid, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_data, seq_err
    );

    modport slave (
        input  in_valid, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_data, seq_err
    );
endinterface

// File: rtl/ka_overlap_accumulator.sv
// XOR-accumulates the L/M/Hi half-products of one Karatsuba level into a 2N-1 bit product.
// Optional macro KA_MID_CORRECT_EN: M arrives uncorrected and the correction is folded into each beat.
module ka_overlap_accumulator #(
    parameter int N = 30
) (
    input logic                    clk,
    input logic                    rst,
    ka_overlap_accumulator_if.slave bus
);
    localparam int H  = N / 2;
    localparam int PW = 2 * N - 1;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_MID = 2'd1,
        S_HI  = 2'd2,
        S_OUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] acc_q, acc_d;
    logic          seq_err_q, seq_err_d;

    logic          in_ready;
    logic          out_valid;
    logic          in_fire;
    logic          out_fire;
    logic [1:0]    exp_tag;
    logic [PW-1:0] term_ext;
    logic [PW-1:0] lo_term;
    logic [PW-1:0] mid_term;
    logic [PW-1:0] hi_term;

    assign out_valid = (state_q == S_OUT);
    // A held product frees the input only when it leaves in this same cycle.
    assign in_ready  = (state_q != S_OUT) | bus.out_ready;
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;
    assign term_ext  = {{N{1'b0}}, bus.in_data};

`ifdef KA_MID_CORRECT_EN
    // (M ^ L ^ Hi) << H is spread across the three beats so no term has to be stored.
    assign lo_term  = term_ext ^ (term_ext << H);
    assign mid_term = term_ext << H;
    assign hi_term  = (term_ext << H) ^ (term_ext << (2 * H));
`else
    assign lo_term  = term_ext;
    assign mid_term = term_ext << H;
    assign hi_term  = term_ext << (2 * H);
`endif

    always_comb begin
        case (state_q)
            S_MID:   exp_tag = 2'd1;
            S_HI:    exp_tag = 2'd2;
            default: exp_tag = 2'd0;
        endcase
    end

    // A tag-0 beat always starts a fresh group, whether expected or a recovery.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        seq_err_d = 1'b0;
        if (out_fire) begin
            state_d = S_LO;
        end
        if (in_fire) begin
            if (bus.in_tag != exp_tag) begin
                seq_err_d = 1'b1;
            end
            if (bus.in_tag == 2'd0) begin
                acc_d   = lo_term;
                state_d = S_MID;
            end else if (bus.in_tag != exp_tag) begin
                state_d = S_LO;
            end else if (bus.in_tag == 2'd1) begin
                acc_d   = acc_q ^ mid_term;
                state_d = S_HI;
            end else begin
                acc_d   = acc_q ^ hi_term;
                state_d = S_OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LO;
            acc_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc_q;
    assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_ka_overlap_accumulator.sv
// Directed bench for ka_overlap_accumulator: reference model of the Karatsuba overlap plus literal spot checks.
// Honours KA_MID_CORRECT_EN the same way as the design build.
module tb_ka_overlap_accumulator;
    localparam int N  = 30;
    localparam int H  = N / 2;
    localparam int TW = N - 1;
    localparam int PW = 2 * N - 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ka_overlap_accumulator_if #(.N(N)) bus();

    ka_overlap_accumulator #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full product of one level from its three half-products.
    function automatic logic [PW-1:0] combine(input logic [TW-1:0] l, input logic [TW-1:0] m,
                                             input logic [TW-1:0] h);
        logic [TW-1:0] mid;
        mid = m;
`ifdef KA_MID_CORRECT_EN
        mid = m ^ l ^ h;
`endif
        return {{N{1'b0}}, l} ^ ({{N{1'b0}}, mid} << H) ^ ({{N{1'b0}}, h} << (2 * H));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] tag, input logic [TW-1:0] data,
                                 input logic ordy);
        bus.in_valid  = v;
        bus.in_tag    = tag;
        bus.in_data   = data;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Model state: which term is expected next, captured terms, and the held product.
    bit            m_live;
    int            m_phase;
    bit            m_hold;
    bit            m_err;
    logic [TW-1:0] m_l;
    logic [TW-1:0] m_m;
    logic [PW-1:0] m_prod;

    initial begin
        m_live  = 0;
        m_phase = 0;
        m_hold  = 0;
        m_err   = 0;
        m_l     = '0;
        m_m     = '0;
        m_prod  = '0;
    end

    // Compare mid-cycle, then advance the model with the inputs the next edge will sample.
    always @(negedge clk) begin
        bit exp_ready;
        bit fire;
        exp_ready = !m_hold || bus.out_ready;
        if (m_live) begin
            checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
            checkOutput("out_valid", {63'd0, bus.out_valid}, {63'd0, m_hold});
            checkOutput("seq_err", {63'd0, bus.seq_err}, {63'd0, m_err});
            if (m_hold) begin
                checkOutput("out_data", {5'd0, bus.out_data}, {5'd0, m_prod});
            end
        end
        if (rst) begin
            m_live  = 1;
            m_phase = 0;
            m_hold  = 0;
            m_err   = 0;
            m_prod  = '0;
        end else begin
            fire  = bus.in_valid && exp_ready;
            m_err = 0;
            if (m_hold && bus.out_ready) begin
                m_hold = 0;
            end
            if (fire) begin
                if (int'(bus.in_tag) != m_phase) begin
                    m_err = 1;
                    if (bus.in_tag == 2'd0) begin
                        m_l     = bus.in_data;
                        m_phase = 1;
                    end else begin
                        m_phase = 0;
                    end
                end else if (m_phase == 0) begin
                    m_l     = bus.in_data;
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_m     = bus.in_data;
                    m_phase = 2;
                end else begin
                    m_prod  = combine(m_l, m_m, bus.in_data);
                    m_hold  = 1;
                    m_phase = 0;
                end
            end
        end
    end

    initial begin
        logic [PW-1:0] held;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_tag    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("reset_seq_err", {63'd0, bus.seq_err}, 64'd0);
        checkOutput("reset_out_data", {5'd0, bus.out_data}, 64'd0);

        // Single-bit terms, consecutive beats.
        applyStimulus(1'b1, 2'd0, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h1, 1'b1);
        checkOutput("p1_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("p1_data", {5'd0, bus.out_data}, 64'h0000_0000_4000_8001);
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);
        checkOutput("p1_drained", {63'd0, bus.out_valid}, 64'd0);

        // Full-width L and M overlap.
        applyStimulus(1'b1, 2'd0, 29'h1FFF_FFFF, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h1FFF_FFFF, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h0, 1'b1);
`ifdef KA_MID_CORRECT_EN
        checkOutput("p2_data", {5'd0, bus.out_data}, 64'h0000_0000_1FFF_FFFF);
`else
        checkOutput("p2_data", {5'd0, bus.out_data}, 64'h0000_0FFF_E000_7FFF);
`endif
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);

        applyStimulus(1'b1, 2'd0, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h0, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h0, 1'b1);
`ifdef KA_MID_CORRECT_EN
        checkOutput("p3_data", {5'd0, bus.out_data}, 64'h8001);
`else
        checkOutput("p3_data", {5'd0, bus.out_data}, 64'h1);
`endif
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);

        // Hi term reaching the top product bit.
        applyStimulus(1'b1, 2'd0, 29'h0, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h0, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h1FFF_FFFF, 1'b1);
`ifndef KA_MID_CORRECT_EN
        checkOutput("p4_data", {5'd0, bus.out_data}, 64'h07FF_FFFF_C000_0000);
`endif
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);

        // Backpressure: held product, blocked L beat, then release with L in the same cycle.
        applyStimulus(1'b1, 2'd0, 29'h3, 1'b0);
        applyStimulus(1'b1, 2'd1, 29'h5, 1'b0);
        applyStimulus(1'b1, 2'd2, 29'h7, 1'b0);
        held = bus.out_data;
`ifdef KA_MID_CORRECT_EN
        checkOutput("bp_data", {5'd0, held}, 64'h1_C000_8003);
`else
        checkOutput("bp_data", {5'd0, held}, 64'h1_C002_8003);
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd0, 29'h1, 1'b0);
            checkOutput("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("bp_hold_data", {5'd0, bus.out_data}, {5'd0, held});
            checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        applyStimulus(1'b1, 2'd0, 29'h1, 1'b1);
        checkOutput("bp_release_valid", {63'd0, bus.out_valid}, 64'd0);
        applyStimulus(1'b1, 2'd1, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h1, 1'b1);
        checkOutput("bb_data", {5'd0, bus.out_data}, 64'h0000_0000_4000_8001);

        // Wrong tag while delivering: product leaves, beat dropped.
        applyStimulus(1'b1, 2'd1, 29'h1, 1'b1);
        checkOutput("out_err_pulse", {63'd0, bus.seq_err}, 64'd1);
        checkOutput("out_err_valid", {63'd0, bus.out_valid}, 64'd0);

        // Sequence error: L then Hi.
        applyStimulus(1'b1, 2'd0, 29'h2, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h5, 1'b1);
        checkOutput("seq_err_pulse", {63'd0, bus.seq_err}, 64'd1);
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);
        checkOutput("seq_err_clear", {63'd0, bus.seq_err}, 64'd0);
        checkOutput("seq_err_no_valid", {63'd0, bus.out_valid}, 64'd0);
        applyStimulus(1'b1, 2'd3, 29'h9, 1'b1);
        applyStimulus(1'b1, 2'd0, 29'h9, 1'b1);
        applyStimulus(1'b1, 2'd0, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h1, 1'b1);
        checkOutput("restart_data", {5'd0, bus.out_data}, 64'h0000_0000_4000_8001);
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);

        // Reset mid-group, then an independent group.
        applyStimulus(1'b1, 2'd0, 29'h55, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h77, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_mid_ready", {63'd0, bus.in_ready}, 64'd1);
        applyStimulus(1'b1, 2'd0, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd1, 29'h1, 1'b1);
        applyStimulus(1'b1, 2'd2, 29'h1, 1'b0);
        checkOutput("rst_mid_data", {5'd0, bus.out_data}, 64'h0000_0000_4000_8001);

        // Reset while a product is held drops it.
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b0);
        rst = 1'b0;
        checkOutput("rst_held_valid", {63'd0, bus.out_valid}, 64'd0);
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);
        applyStimulus(1'b0, 2'd0, 29'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
